// File: rtl/falling_block_engine.sv
// Falling-block engine for the block-catcher game: once per frame it erases, moves,
// checks and redraws every active block, then may spawn a new one, streaming pixel writes.
module falling_block_engine #(
  parameter int NUM_BLOCKS   = 8,
  parameter int BLOCK_SIZE   = 4,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int PADDLE_Y     = 110,
  parameter int PADDLE_W     = 12,
  parameter int SPAWN_THRESH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [15:0] rng,
  input  logic [7:0]  paddle_x,
  output logic        plot,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        busy,
  output logic        caught,
  output logic        missed
);

  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_SELECT     = 4'd1;
  localparam logic [3:0] S_ERASE      = 4'd2;
  localparam logic [3:0] S_MOVE       = 4'd3;
  localparam logic [3:0] S_CHECK      = 4'd4;
  localparam logic [3:0] S_DRAW       = 4'd5;
  localparam logic [3:0] S_NEXT       = 4'd6;
  localparam logic [3:0] S_SPAWN      = 4'd7;
  localparam logic [3:0] S_SPAWN_DRAW = 4'd8;

  logic [3:0]    state, state_next;
  logic [IW-1:0] i;
  logic [CW-1:0] row, col;
  logic [8:0]    by_new;

  logic [NUM_BLOCKS-1:0] active;
  logic [7:0]            bx    [NUM_BLOCKS];
  logic [7:0]            by    [NUM_BLOCKS];
  logic [2:0]            bcol  [NUM_BLOCKS];
  logic [2:0]            speed [NUM_BLOCKS];

  logic          last_pix, last_slot;
  logic [8:0]    old_bot, new_bot, blk_right, pad_right;
  logic          hit, floor_hit;
  logic          free_found, spawn_ok;
  logic [IW-1:0] free_idx;
  logic [7:0]    spawn_bx;
  logic [2:0]    spawn_col, spawn_speed;
  logic          unused_rng;

  assign unused_rng = rng[7];

  assign last_pix  = (row == CW'(BLOCK_SIZE - 1)) && (col == CW'(BLOCK_SIZE - 1));
  assign last_slot = (i == IW'(NUM_BLOCKS - 1));

  // Catch needs the bottom edge to cross the paddle row this frame, so a block
  // already below the paddle can never be caught late.
  assign old_bot   = {1'b0, by[i]} + 9'(BLOCK_SIZE - 1);
  assign new_bot   = by_new + 9'(BLOCK_SIZE - 1);
  assign blk_right = {1'b0, bx[i]} + 9'(BLOCK_SIZE - 1);
  assign pad_right = {1'b0, paddle_x} + 9'(PADDLE_W - 1);
  assign hit       = (old_bot < 9'(PADDLE_Y)) && (new_bot >= 9'(PADDLE_Y)) &&
                     (blk_right >= {1'b0, paddle_x}) && ({1'b0, bx[i]} <= pad_right);
  assign floor_hit = (new_bot >= 9'(SCREEN_H));

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_BLOCKS - 1; k >= 0; k--) begin
      if (!active[k]) begin
        free_found = 1'b1;
        free_idx   = IW'(k);
      end
    end
  end

  assign spawn_ok    = free_found && (rng[3:0] < 4'(SPAWN_THRESH));
  assign spawn_bx    = (rng[15:8] > 8'(SCREEN_W - BLOCK_SIZE)) ?
                       rng[15:8] - 8'(SCREEN_W - BLOCK_SIZE) : rng[15:8];
  assign spawn_col   = (rng[6:4] == 3'b000) ? 3'b111 : rng[6:4];
  assign spawn_speed = {1'b0, rng[9:8]} + 3'd1;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (frame_tick && enable) state_next = S_SELECT;
      S_SELECT:     if (active[i]) state_next = S_ERASE;
                    else if (last_slot) state_next = S_SPAWN;
      S_ERASE:      if (last_pix) state_next = S_MOVE;
      S_MOVE:       state_next = S_CHECK;
      S_CHECK:      state_next = (hit || floor_hit) ? S_NEXT : S_DRAW;
      S_DRAW:       if (last_pix) state_next = S_NEXT;
      S_NEXT:       state_next = last_slot ? S_SPAWN : S_SELECT;
      S_SPAWN:      state_next = spawn_ok ? S_SPAWN_DRAW : S_IDLE;
      S_SPAWN_DRAW: if (last_pix) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Pixel outputs are registered, so each write appears one cycle after its scan step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      i      <= '0;
      row    <= '0;
      col    <= '0;
      by_new <= '0;
      active <= '0;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        bx[k]    <= '0;
        by[k]    <= '0;
        bcol[k]  <= '0;
        speed[k] <= '0;
      end
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      busy   <= 1'b0;
      caught <= 1'b0;
      missed <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != S_IDLE);
      plot   <= 1'b0;
      caught <= 1'b0;
      missed <= 1'b0;
      case (state)
        S_IDLE: begin
          i   <= '0;
          row <= '0;
          col <= '0;
        end
        // An empty slot is skipped in a single cycle without visiting NEXT.
        S_SELECT: if (!active[i] && !last_slot) i <= i + 1'b1;
        S_ERASE, S_DRAW, S_SPAWN_DRAW: begin
          plot   <= 1'b1;
          x      <= bx[i] + 8'(col);
          y      <= by[i] + 8'(row);
          colour <= (state == S_ERASE) ? 3'b000 : bcol[i];
          if (col == CW'(BLOCK_SIZE - 1)) begin
            col <= '0;
            row <= (row == CW'(BLOCK_SIZE - 1)) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_MOVE: by_new <= {1'b0, by[i]} + 9'(speed[i]);
        S_CHECK: begin
          if (hit) begin
            active[i] <= 1'b0;
            caught    <= 1'b1;
          end else if (floor_hit) begin
            active[i] <= 1'b0;
            missed    <= 1'b1;
          end else begin
            by[i] <= by_new[7:0];
          end
        end
        S_NEXT: if (!last_slot) i <= i + 1'b1;
        S_SPAWN: begin
          if (spawn_ok) begin
            active[free_idx] <= 1'b1;
            bx[free_idx]     <= spawn_bx;
            by[free_idx]     <= '0;
            bcol[free_idx]   <= spawn_col;
            speed[free_idx]  <= spawn_speed;
            i                <= free_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_falling_block_engine.sv
// Directed bench for falling_block_engine: a table of whole frames with expected
// pixel/busy/pulse counts, plus hand sequences for pixel order, ignored ticks and reset.
module tb_falling_block_engine;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        frame_tick = 1'b0;
  logic [15:0] rng = 16'h0000;
  logic [7:0]  paddle_x = 8'd0;
  logic        plot;
  logic [7:0]  x, y;
  logic [2:0]  colour;
  logic        busy, caught, missed;

  falling_block_engine dut (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
    .rng(rng), .paddle_x(paddle_x), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .caught(caught), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_reset;
    logic [15:0] rng;
    logic [7:0]  pad;
    int          plots;
    int          busy;
    int          caught;
    int          missed;
    bit          chk_first;
    int          fx, fy, fc;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   plot_cnt, busy_cnt, caught_cnt, missed_cnt;
  int   px_q[$], py_q[$], pc_q[$];

  always @(negedge clk) begin
    if (plot) begin
      plot_cnt++;
      px_q.push_back(int'(x));
      py_q.push_back(int'(y));
      pc_q.push_back(int'(colour));
    end
    if (busy) busy_cnt++;
    if (caught) caught_cnt++;
    if (missed) missed_cnt++;
  end

  function automatic void addVec(bit rst, logic [15:0] r, logic [7:0] p, int pl, int bz,
                                 int ca, int mi, bit cf, int fx, int fy, int fc, string nm);
    vec_t v;
    v.do_reset = rst; v.rng = r; v.pad = p; v.plots = pl; v.busy = bz;
    v.caught = ca; v.missed = mi; v.chk_first = cf; v.fx = fx; v.fy = fy; v.fc = fc;
    v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearCounters();
    plot_cnt = 0; busy_cnt = 0; caught_cnt = 0; missed_cnt = 0;
    px_q.delete(); py_q.delete(); pc_q.delete();
  endtask

  task automatic doReset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseTick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput({name, ".timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // One full frame: set inputs, pulse the tick, wait until the update finishes.
  task automatic applyStimulus(input logic [15:0] r, input logic [7:0] p, input string name);
    rng = r;
    paddle_x = p;
    clearCounters();
    pulseTick();
    waitIdle(name);
  endtask

  initial begin
    vec_t v;
    int   exp_x, exp_y, exp_c, k2, held;

    // Empty frames, first spawn, first fall.
    addVec(1, 16'h000F, 8'd0, 0, 9, 0, 0, 0, 0, 0, 0, "idle1");
    addVec(0, 16'h000F, 8'd0, 0, 9, 0, 0, 0, 0, 0, 0, "idle2");
    addVec(0, 16'h000F, 8'd0, 0, 9, 0, 0, 0, 0, 0, 0, "idle3");
    addVec(0, 16'h2311, 8'd0, 16, 25, 0, 0, 1, 35, 0, 1, "spawn2311");
    addVec(0, 16'h000F, 8'd0, 32, 44, 0, 0, 1, 35, 0, 0, "fall1");
    // Speed-4 block at bx=75 falls to by=104, then lands on the paddle's right edge.
    addVec(1, 16'h4B01, 8'd0, 16, 25, 0, 0, 1, 75, 0, 7, "spawnB");
    for (int k = 1; k <= 26; k++)
      addVec(0, 16'h000F, 8'd0, 32, 44, 0, 0, 1, 75, 4 * (k - 1), 0, $sformatf("fallB%0d", k));
    addVec(0, 16'h000F, 8'd64, 16, 28, 1, 0, 1, 75, 104, 0, "catchEdge");
    addVec(0, 16'h000F, 8'd64, 0, 9, 0, 0, 0, 0, 0, 0, "afterCatch");
    // Same fall, paddle one column too far right: block passes and is missed at the floor.
    addVec(1, 16'h4B01, 8'd0, 16, 25, 0, 0, 0, 0, 0, 0, "spawnC");
    for (int k = 1; k <= 26; k++)
      addVec(0, 16'h000F, 8'd0, 32, 44, 0, 0, 0, 0, 0, 0, $sformatf("fallC%0d", k));
    addVec(0, 16'h000F, 8'd79, 32, 44, 0, 0, 1, 75, 104, 0, "passPaddle");
    addVec(0, 16'h000F, 8'd0, 32, 44, 0, 0, 1, 75, 108, 0, "fallC28");
    addVec(0, 16'h000F, 8'd0, 32, 44, 0, 0, 1, 75, 112, 0, "fallC29");
    addVec(0, 16'h000F, 8'd0, 16, 28, 0, 1, 1, 75, 116, 0, "missFloor");
    addVec(0, 16'h000F, 8'd0, 0, 9, 0, 0, 0, 0, 0, 0, "afterMiss");
    // Spawn threshold, column wrap, colour 000 -> 111, exact right-edge column.
    addVec(1, 16'h9D04, 8'd0, 0, 9, 0, 0, 0, 0, 0, 0, "threshNo");
    addVec(0, 16'h9D03, 8'd0, 16, 25, 0, 0, 1, 1, 0, 7, "wrapSpawn");
    addVec(0, 16'h9C02, 8'd0, 48, 60, 0, 0, 1, 1, 0, 0, "edgeSpawn");
    addVec(0, 16'h000F, 8'd0, 64, 79, 0, 0, 1, 1, 2, 0, "twoBlocks");
    // Fill all eight slots, then an eligible rng must not spawn.
    for (int j = 0; j < 8; j++)
      addVec(j == 0, 16'h1001, 8'd0, 32 * j + 16, 35 * j + 25, 0, 0, j == 0, 16, 0, 7,
             $sformatf("fill%0d", j));
    addVec(0, 16'h1001, 8'd0, 256, 289, 0, 0, 0, 0, 0, 0, "fullNoSpawn");

    // Reset values while resetn is held low.
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.plot", int'(plot), 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.caught", int'(caught), 0);
    checkOutput("reset.missed", int'(missed), 0);
    checkOutput("reset.xyc", int'({x, y, colour}), 0);

    foreach (vecs[n]) begin
      v = vecs[n];
      if (v.do_reset) doReset();
      applyStimulus(v.rng, v.pad, v.name);
      checkOutput({v.name, ".plots"}, plot_cnt, v.plots);
      checkOutput({v.name, ".busy"}, busy_cnt, v.busy);
      checkOutput({v.name, ".caught"}, caught_cnt, v.caught);
      checkOutput({v.name, ".missed"}, missed_cnt, v.missed);
      if (v.chk_first) begin
        checkOutput({v.name, ".havePixel"}, int'(px_q.size() > 0), 1);
        if (px_q.size() > 0) begin
          checkOutput({v.name, ".firstX"}, px_q[0], v.fx);
          checkOutput({v.name, ".firstY"}, py_q[0], v.fy);
          checkOutput({v.name, ".firstC"}, pc_q[0], v.fc);
        end
      end
    end

    // Full erase/draw pixel order for the second frame of the 2311 block.
    doReset();
    applyStimulus(16'h2311, 8'd0, "order.spawn");
    applyStimulus(16'h000F, 8'd0, "order.frame");
    checkOutput("order.count", px_q.size(), 32);
    for (int k = 0; k < 32 && k < px_q.size(); k++) begin
      k2 = (k < 16) ? k : k - 16;
      exp_x = 35 + k2 % 4;
      exp_y = ((k < 16) ? 0 : 4) + k2 / 4;
      exp_c = (k < 16) ? 0 : 1;
      checkOutput($sformatf("order.pix%0d", k), px_q[k] * 4096 + py_q[k] * 8 + pc_q[k],
                  exp_x * 4096 + exp_y * 8 + exp_c);
    end

    // A second tick during ERASE must not start another frame.
    doReset();
    applyStimulus(16'h2311, 8'd0, "busyTick.spawn");
    rng = 16'h000F;
    clearCounters();
    pulseTick();
    repeat (5) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    waitIdle("busyTick");
    repeat (20) @(negedge clk);
    checkOutput("busyTick.plots", plot_cnt, 32);
    checkOutput("busyTick.busy", busy_cnt, 44);

    // A tick with enable low is ignored.
    enable = 1'b0;
    clearCounters();
    pulseTick();
    repeat (10) @(negedge clk);
    checkOutput("disabled.busy", busy_cnt, 0);
    checkOutput("disabled.plots", plot_cnt, 0);
    enable = 1'b1;

    // Reset asserted mid-DRAW stops writes at once and empties every slot.
    doReset();
    applyStimulus(16'h2311, 8'd0, "midReset.spawn");
    rng = 16'h000F;
    clearCounters();
    pulseTick();
    for (int c = 0; c < 200 && plot_cnt < 20; c++) @(posedge clk);
    checkOutput("midReset.reachedDraw", int'(plot_cnt >= 20), 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midReset.plot", int'(plot), 0);
    checkOutput("midReset.busy", int'(busy), 0);
    held = plot_cnt;
    repeat (5) @(negedge clk);
    checkOutput("midReset.noWrites", plot_cnt, held);
    #1 resetn = 1'b1;
    @(posedge clk);
    applyStimulus(16'h000F, 8'd0, "midReset.after");
    checkOutput("midReset.afterPlots", plot_cnt, 0);
    checkOutput("midReset.afterBusy", busy_cnt, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
